// File: rtl/fetch_pc_stage_pkg.sv
// Shared constants and types for the instruction-fetch PC stage.
package fetch_pc_stage_pkg;

    localparam int          FETCH_PC_W     = 12;
    localparam int          FETCH_INSN_W   = 32;
    localparam logic [11:0] FETCH_RESET_PC = 12'h000;
    localparam logic [31:0] FETCH_NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_stage_cla.sv
// 12-bit carry-lookahead adder: three 4-bit lookahead groups chained by group generate/propagate.
// There is no carry-out; the sum wraps modulo 4096.
module cla_twelve (
    input  logic [11:0] in1,
    input  logic [11:0] in2,
    input  logic        cin,
    output logic [11:0] sum
);

    // Bit 11 generate would only feed a carry-out, which this adder does not expose.
    logic [10:0] g;
    logic [11:0] p;
    logic [11:0] c;
    logic [2:0]  cg;
    logic [1:0]  gg;
    logic [1:0]  gp;

    assign g     = in1[10:0] & in2[10:0];
    assign p     = in1 ^ in2;
    assign cg[0] = cin;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_grp
            localparam int B = 4 * gi;
            assign c[B]   = cg[gi];
            assign c[B+1] = g[B] | (p[B] & cg[gi]);
            assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & cg[gi]);
            assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                          | (p[B+2] & p[B+1] & p[B] & cg[gi]);
            if (gi < 2) begin : g_gp
                assign gg[gi]    = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                                 | (p[B+3] & p[B+2] & p[B+1] & g[B]);
                assign gp[gi]    = &p[B+3:B];
                assign cg[gi+1]  = gg[gi] | (gp[gi] & cg[gi]);
            end
        end
    endgenerate

    assign sum = p ^ c;

endmodule

// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: PC register, synchronous imem request, F/D latch with stall and redirect squash.
// Optional FETCH_PERF_EN adds fetched/bubble performance counters.
module fetch_pc_stage
    import fetch_pc_stage_pkg::*;
#(
    parameter int               PC_W     = FETCH_PC_W,
    parameter int               INSN_W   = FETCH_INSN_W,
    parameter logic [PC_W-1:0]  RESET_PC = FETCH_RESET_PC
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_target,
    output logic [PC_W-1:0]   imem_addr,
    output logic              imem_en,
    input  logic [INSN_W-1:0] imem_rdata,
    output logic              fd_valid,
    output logic [PC_W-1:0]   fd_pc,
    output logic [PC_W-1:0]   fd_pc_plus1,
    output logic [INSN_W-1:0] fd_insn
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       perf_fetched,
    output logic [15:0]       perf_bubbles
`endif
);

    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   req_pc_q, req_pc_d;
    logic [PC_W-1:0]   fd_pc_q, fd_pc_d;
    logic [PC_W-1:0]   fd_pc_plus1_q, fd_pc_plus1_d;
    logic [INSN_W-1:0] fd_insn_q, fd_insn_d;
    logic [PC_W-1:0]   pc_plus1;
    logic [PC_W-1:0]   req_pc_plus1;
    logic              advance;
    logic              wr_valid;

    cla_twelve u_pc_inc (
        .in1 (pc_q),
        .in2 (12'd1),
        .cin (1'b0),
        .sum (pc_plus1)
    );

    cla_twelve u_req_inc (
        .in1 (req_pc_q),
        .in2 (12'd1),
        .cin (1'b0),
        .sum (req_pc_plus1)
    );

    // A redirect moves the pipe even when decode is stalled.
    assign advance   = ~stall | redirect_valid;
    assign wr_valid  = ~redirect_valid & (state_q != BOOT);
    assign imem_en   = advance;
    assign imem_addr = pc_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        fd_pc_d       = fd_pc_q;
        fd_pc_plus1_d = fd_pc_plus1_q;
        fd_insn_d     = fd_insn_q;
        if (redirect_valid) begin
            state_d = BOOT;
            pc_d    = redirect_target;
        end else if (!stall) begin
            pc_d = pc_plus1;
            case (state_q)
                BOOT:    state_d = FILL;
                FILL:    state_d = RUN;
                default: state_d = RUN;
            endcase
        end
        if (advance) begin
            req_pc_d      = pc_q;
            fd_pc_d       = req_pc_q;
            fd_pc_plus1_d = req_pc_plus1;
            fd_insn_d     = imem_rdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            fd_pc_q       <= '0;
            fd_pc_plus1_q <= '0;
            fd_insn_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            fd_pc_q       <= fd_pc_d;
            fd_pc_plus1_q <= fd_pc_plus1_d;
            fd_insn_q     <= fd_insn_d;
        end
    end

    assign fd_valid    = (state_q == RUN);
    assign fd_pc       = fd_pc_q;
    assign fd_pc_plus1 = fd_pc_plus1_q;
    assign fd_insn     = fd_insn_q;

`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched_q, perf_fetched_d;
    logic [15:0] perf_bubbles_q, perf_bubbles_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_bubbles_d = perf_bubbles_q;
        if (advance) begin
            if (wr_valid) begin
                perf_fetched_d = perf_fetched_q + 16'd1;
            end else begin
                perf_bubbles_d = perf_bubbles_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched_q <= '0;
            perf_bubbles_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_bubbles_q <= perf_bubbles_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`endif

endmodule
